// File: rtl/gcd_arbiter_if.sv
// Request/response and engine-side signal bundle for gcd_arbiter.
// slave is the arbiter's view; master is the view of the clients and engine around it.
interface gcd_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 32
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*DW-1:0] req_opa;
   logic [NREQ*DW-1:0] req_opb;
   logic [NREQ-1:0]    rsp_valid;
   logic [NREQ-1:0]    rsp_ready;
   logic [DW-1:0]      rsp_result;
   logic               busy;
   logic [DW-1:0]      gcd_opa;
   logic [DW-1:0]      gcd_opb;
   logic               gcd_start;
   logic               gcd_done;
   logic [DW-1:0]      gcd_result;

   modport slave (
      input  req_valid, req_opa, req_opb, rsp_ready, gcd_done, gcd_result,
      output req_ready, rsp_valid, rsp_result, busy, gcd_opa, gcd_opb, gcd_start
   );

   modport master (
      output req_valid, req_opa, req_opb, rsp_ready, gcd_done, gcd_result,
      input  req_ready, rsp_valid, rsp_result, busy, gcd_opa, gcd_opb, gcd_start
   );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin scheduler sharing one gcd engine among NREQ requesters.
// Define GCD_ARB_ZERO_BYPASS_EN to answer jobs with a zero operand without the engine.
module gcd_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 32
) (
   input logic          clk,
   input logic          reset,
   gcd_arbiter_if.slave bus
);
   localparam int unsigned     IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [2:0] {StIdle, StIssue, StGuard, StWait, StResp} state_t;

   state_t          r_state;
   logic [IW-1:0]   r_rr_ptr;
   logic [IW-1:0]   r_owner;
   logic [DW-1:0]   r_opa;
   logic [DW-1:0]   r_opb;
   logic [DW-1:0]   r_rsp_result;
   logic            r_start;
   logic            r_busy;
   logic [NREQ-1:0] r_rsp_valid;

   logic            w_found;
   logic [IW-1:0]   w_grant;
   logic [IW-1:0]   w_next_ptr;
   logic [DW-1:0]   w_acc_opa;
   logic [DW-1:0]   w_acc_opb;
   logic            w_accept;

   // First valid requester at or after the round-robin pointer.
   always_comb begin : p_grant
      logic [IW-1:0] v_cand;
      w_found = 1'b0;
      w_grant = '0;
      v_cand  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         v_cand = IW'((32'(r_rr_ptr) + k) % NREQ);
         if (!w_found && bus.req_valid[v_cand]) begin
            w_found = 1'b1;
            w_grant = v_cand;
         end
      end
   end

   assign w_accept   = (r_state == StIdle) && w_found;
   assign w_next_ptr = (32'(w_grant) == NREQ - 1) ? '0 : w_grant + IW'(1);
   assign w_acc_opa  = bus.req_opa[32'(w_grant) * DW +: DW];
   assign w_acc_opb  = bus.req_opb[32'(w_grant) * DW +: DW];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= StIdle;
         r_rr_ptr     <= '0;
         r_owner      <= '0;
         r_opa        <= '0;
         r_opb        <= '0;
         r_rsp_result <= '0;
         r_start      <= 1'b0;
         r_busy       <= 1'b0;
         r_rsp_valid  <= '0;
      end else begin
         r_start <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_owner  <= w_grant;
                  r_opa    <= w_acc_opa;
                  r_opb    <= w_acc_opb;
                  r_rr_ptr <= w_next_ptr;
                  r_busy   <= 1'b1;
`ifdef GCD_ARB_ZERO_BYPASS_EN
                  // gcd(x,0) = x and gcd(0,0) = 0, so the OR is the answer.
                  if (w_acc_opa == '0 || w_acc_opb == '0) begin
                     r_rsp_result <= w_acc_opa | w_acc_opb;
                     r_rsp_valid  <= ONE << w_grant;
                     r_state      <= StResp;
                  end else begin
                     r_start <= 1'b1;
                     r_state <= StIssue;
                  end
`else
                  r_start <= 1'b1;
                  r_state <= StIssue;
`endif
               end
            end
            StIssue: r_state <= StGuard;
            // Engine done still reflects the previous job here.
            StGuard: r_state <= StWait;
            StWait: begin
               if (bus.gcd_done) begin
                  r_rsp_result <= bus.gcd_result;
                  r_rsp_valid  <= ONE << r_owner;
                  r_state      <= StResp;
               end
            end
            StResp: begin
               if (bus.rsp_ready[r_owner]) begin
                  r_rsp_valid <= '0;
                  r_busy      <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.req_ready  = w_accept ? (ONE << w_grant) : '0;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_result = r_rsp_result;
   assign bus.busy       = r_busy;
   assign bus.gcd_opa    = r_opa;
   assign bus.gcd_opb    = r_opb;
   assign bus.gcd_start  = r_start;
endmodule

// File: tb/tb_gcd_arbiter.sv
// Randomized self-checking bench for gcd_arbiter with a behavioural gcd engine
// and a queue-based round-robin reference model.
module tb_gcd_arbiter;
   localparam int unsigned NREQ = 4;
   localparam int unsigned DW   = 32;

   typedef struct packed {
      logic [2:0]  req;
      logic [31:0] a;
      logic [31:0] b;
   } job_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   gcd_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

   gcd_arbiter #(.NREQ(NREQ), .DW(DW)) u_dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] gcd_ref(input logic [31:0] a_i, input logic [31:0] b_i);
      logic [31:0] x, y, t;
      x = a_i;
      y = b_i;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Engine: sees start one cycle late, so done stays up through the arbiter's guard cycle.
   logic eng_sq, eng_sqq;
   int   eng_cnt;
   int   eng_fixed = 0;
   always @(posedge clk) begin
      if (rst) begin
         eng_sq         <= 1'b0;
         eng_sqq        <= 1'b0;
         eng_cnt        <= 0;
         bus.gcd_done   <= 1'b0;
         bus.gcd_result <= '0;
      end else begin
         eng_sq  <= bus.gcd_start;
         eng_sqq <= eng_sq;
         if (eng_sq && !eng_sqq) begin
            bus.gcd_done   <= 1'b0;
            bus.gcd_result <= gcd_ref(bus.gcd_opa, bus.gcd_opb);
            eng_cnt        <= (eng_fixed > 0) ? eng_fixed : int'($urandom_range(1, 5));
         end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) bus.gcd_done <= 1'b1;
         end
      end
   end

   // Reference model state
   job_t        pend[$];
   int          m_rr = 0;
   bit          m_busy = 0;
   int          m_owner = 0;
   logic [31:0] m_a, m_b, m_exp;
   bit          m_byp = 0;
   int          m_starts = 0;
   int          m_rsp_cnt = 0;
   int          m_wait = 0;
   int          m_acc_cyc = 0;
   int          cyc = 0;
   int          glog[$];
   logic [31:0] rlog[$];
   int          hlog[$];
   bit          rand_mode = 0;
   int          rdy_mode = 0;

   function automatic int head_idx(input int r);
      for (int k = 0; k < pend.size(); k++)
         if (int'(pend[k].req) == r) return k;
      return -1;
   endfunction

   function automatic int exp_grant(input logic [NREQ-1:0] v);
      for (int k = 0; k < int'(NREQ); k++)
         if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
      return -1;
   endfunction

   task automatic push_job(input int r, input logic [31:0] a, input logic [31:0] b);
      job_t j;
      j.req = 3'(r);
      j.a   = a;
      j.b   = b;
      pend.push_back(j);
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 3))
         0:       return 32'd0;
         1:       return $urandom;
         default: return 32'($urandom_range(1, 500));
      endcase
   endfunction

   task automatic step();
      int              g, h, dg;
      logic [NREQ-1:0] oh, exp_rdy, exp_rv;
      @(negedge clk);
      cyc++;
      if (rand_mode) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            h = head_idx(i);
            if (h < 0 && $urandom_range(0, 5) == 0) push_job(i, rand_opnd(), rand_opnd());
            else if (h >= 0 && $urandom_range(0, 39) == 0) pend.delete(h);
         end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
         h = head_idx(i);
         bus.req_valid[i] = (h >= 0);
         bus.req_opa[i*DW +: DW] = (h >= 0) ? pend[h].a : $urandom;
         bus.req_opb[i*DW +: DW] = (h >= 0) ? pend[h].b : $urandom;
      end
      #1;
      oh      = NREQ'(1) << m_owner;
      g       = m_busy ? -1 : exp_grant(bus.req_valid);
      exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
      check_eq("req_ready", bus.req_ready, exp_rdy);
      check_eq("busy", bus.busy, m_busy);
      if (!m_busy) check_eq("gcd_start_idle", bus.gcd_start, 0);
      if (m_busy && bus.rsp_valid[m_owner]) begin
         m_rsp_cnt++;
         if (m_rsp_cnt == 1) begin
            if (m_byp) check_eq("bypass_latency", cyc - m_acc_cyc, 1);
            else check_eq("min_latency", 64'(cyc - m_acc_cyc >= 4), 1);
         end
      end
      exp_rv = (m_busy && m_rsp_cnt > 0) ? oh : '0;
      check_eq("rsp_valid", bus.rsp_valid, exp_rv);
      if (m_rsp_cnt > 0) check_eq("rsp_result", bus.rsp_result, m_exp);
      if (bus.gcd_start) begin
         m_starts++;
         check_eq("gcd_opa", bus.gcd_opa, m_a);
         check_eq("gcd_opb", bus.gcd_opb, m_b);
      end
      for (int i = 0; i < int'(NREQ); i++)
         bus.rsp_ready[i] = (rdy_mode == 0) ? 1'b1 :
                            (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (m_rsp_cnt > 10);
      #1;
      if (m_busy && bus.rsp_valid[m_owner] && bus.rsp_ready[m_owner]) begin
         check_eq("start_pulses", m_starts, m_byp ? 0 : 1);
         rlog.push_back(bus.rsp_result);
         hlog.push_back(m_rsp_cnt);
         m_busy = 0;
      end else if (g >= 0) begin
         dg = -1;
         for (int i = 0; i < int'(NREQ); i++)
            if (bus.req_ready[i] && bus.req_valid[i]) dg = i;
         glog.push_back(dg);
         h         = head_idx(g);
         m_owner   = g;
         m_a       = pend[h].a;
         m_b       = pend[h].b;
         m_exp     = gcd_ref(m_a, m_b);
`ifdef GCD_ARB_ZERO_BYPASS_EN
         m_byp     = (m_a == 0) || (m_b == 0);
`else
         m_byp     = 0;
`endif
         pend.delete(h);
         m_rr      = (g + 1) % NREQ;
         m_busy    = 1;
         m_starts  = 0;
         m_rsp_cnt = 0;
         m_wait    = 0;
         m_acc_cyc = cyc;
      end else if (m_busy) begin
         m_wait++;
         if (m_wait > 300) begin
            check_eq("job_timeout", bus.rsp_valid, oh);
            m_busy = 0;
         end
      end
   endtask

   task automatic run_until_idle(input int max_cyc);
      int n;
      n = 0;
      while ((m_busy || pend.size() != 0) && n < max_cyc) begin
         step();
         n++;
      end
      if (m_busy || pend.size() != 0)
         check_eq("drain_timeout", 64'(pend.size()) + 64'(m_busy), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      @(negedge clk);
      #1;
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_req_ready", bus.req_ready, 0);
      check_eq("rst_rsp_valid", bus.rsp_valid, 0);
      check_eq("rst_rsp_result", bus.rsp_result, 0);
      check_eq("rst_gcd_start", bus.gcd_start, 0);
      check_eq("rst_gcd_opa", bus.gcd_opa, 0);
      check_eq("rst_gcd_opb", bus.gcd_opb, 0);
      @(negedge clk);
      rst = 1'b0;
      m_rr = 0;
      m_busy = 0;
      m_rsp_cnt = 0;
      pend.delete();
   endtask

   task automatic clear_logs();
      glog.delete();
      rlog.delete();
      hlog.delete();
   endtask

   initial begin
      int          exp_g[4];
      logic [31:0] exp_r[4];
      bus.req_valid = '0;
      bus.req_opa   = '0;
      bus.req_opb   = '0;
      bus.rsp_ready = '0;
      do_reset();

      // Single job from requester 0
      clear_logs();
      push_job(0, 48, 18);
      run_until_idle(200);
      check_eq("t1_count", rlog.size(), 1);
      check_eq("t1_grant", glog[0], 0);
      check_eq("t1_result", rlog[0], 6);

      // Four simultaneous requests from a fresh reset
      do_reset();
      clear_logs();
      push_job(0, 12, 8);
      push_job(1, 35, 14);
      push_job(2, 17, 5);
      push_job(3, 100, 75);
      run_until_idle(400);
      exp_g = '{0, 1, 2, 3};
      exp_r = '{32'd4, 32'd7, 32'd1, 32'd25};
      check_eq("t2_count", rlog.size(), 4);
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("t2_grant%0d", k), glog[k], exp_g[k]);
         check_eq($sformatf("t2_result%0d", k), rlog[k], exp_r[k]);
      end

      // Pointer moves to 2, then requesters 1 and 3 compete continuously
      push_job(1, 24, 36);
      run_until_idle(200);
      clear_logs();
      push_job(1, 7, 3);
      push_job(3, 81, 27);
      push_job(1, 64, 48);
      push_job(3, 13, 13);
      run_until_idle(400);
      exp_g = '{3, 1, 3, 1};
      exp_r = '{32'd27, 32'd1, 32'd13, 32'd16};
      check_eq("t3_count", rlog.size(), 4);
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("t3_grant%0d", k), glog[k], exp_g[k]);
         check_eq($sformatf("t3_result%0d", k), rlog[k], exp_r[k]);
      end

      // Response backpressure while another requester waits
      do_reset();
      clear_logs();
      rdy_mode = 2;
      push_job(0, 270, 192);
      step();
      push_job(2, 10, 4);
      run_until_idle(400);
      rdy_mode = 0;
      check_eq("t4_count", rlog.size(), 2);
      check_eq("t4_result", rlog[0], 6);
      check_eq("t4_hold_cycles", hlog[0], 11);
      check_eq("t4_grant0", glog[0], 0);
      check_eq("t4_grant1", glog[1], 2);

      // Reset while waiting on the engine
      clear_logs();
      eng_fixed = 30;
      push_job(0, 48, 18);
      for (int k = 0; k < 6; k++) step();
      check_eq("t5_busy_before", bus.busy, 1);
      do_reset();
      eng_fixed = 0;
      for (int k = 0; k < 5; k++) step();
      push_job(0, 9, 6);
      run_until_idle(200);
      check_eq("t5_count", rlog.size(), 1);
      check_eq("t5_result", rlog[0], 3);

      // Zero operands
      do_reset();
      clear_logs();
      push_job(0, 0, 21);
      run_until_idle(200);
      push_job(1, 0, 0);
      run_until_idle(200);
      check_eq("t6_count", rlog.size(), 2);
      check_eq("t6_result0", rlog[0], 21);
      check_eq("t6_result1", rlog[1], 0);

      // Random traffic, drops and backpressure
      do_reset();
      rdy_mode  = 1;
      rand_mode = 1;
      for (int k = 0; k < 2000; k++) step();
      rand_mode = 0;
      run_until_idle(1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
